// File: rtl/ps2_keypress_capture.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 clock/data pins,
// deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop)
// and keeps a two-byte history of received scan codes in key_press.
// A partial frame that stalls for TIMEOUT_CYCLES clk cycles is abandoned.
module ps2_keypress_capture #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ps2_clk,
    input  logic        ps2_dat,
    output logic [15:0] key_press,
    output logic        byte_valid,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Frame is acceptable when the data byte plus parity bit has an odd
    // number of ones and the stop bit is high.
    function automatic logic frame_ok(input logic [7:0] data,
                                      input logic       par,
                                      input logic       stp);
        frame_ok = (^{data, par}) & stp;
    endfunction

    // Synchroniser chains: _p0 is the metastability flop, _p1 the first
    // usable value, _p2 (clock path only) the previous usable value.
    logic ps2_clk_p0, ps2_clk_p1, ps2_clk_p2;
    logic ps2_dat_p0, ps2_dat_p1;
    logic fall;

    state_t         state;
    logic [3:0]     bit_cnt;
    logic [7:0]     sh;
    logic           par_bit;
    logic [TW-1:0]  to_cnt;

    // Bring the asynchronous PS/2 pins into the clk domain; idle-high reset
    // so no spurious falling edge is seen when reset is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_p0 <= 1'b1;
            ps2_clk_p1 <= 1'b1;
            ps2_clk_p2 <= 1'b1;
            ps2_dat_p0 <= 1'b1;
            ps2_dat_p1 <= 1'b1;
        end else begin
            ps2_clk_p0 <= ps2_clk;
            ps2_clk_p1 <= ps2_clk_p0;
            ps2_clk_p2 <= ps2_clk_p1;
            ps2_dat_p0 <= ps2_dat;
            ps2_dat_p1 <= ps2_dat_p0;
        end
    end

    // Single-cycle strobe on each synchronised PS/2 clock falling edge.
    assign fall = ps2_clk_p2 & ~ps2_clk_p1;

    // Frame FSM with timeout, history register and registered pulses.
    // A falling edge takes priority over an expiring timeout.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            bit_cnt    <= 4'd0;
            sh         <= 8'h00;
            par_bit    <= 1'b0;
            to_cnt     <= '0;
            key_press  <= 16'h0000;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!ps2_dat_p1) begin
                            state   <= DATA;
                            bit_cnt <= 4'd0;
                        end
                    end
                    DATA: begin
                        sh      <= {ps2_dat_p1, sh[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par_bit <= ps2_dat_p1;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (frame_ok(sh, par_bit, ps2_dat_p1)) begin
                            key_press  <= {key_press[7:0], sh};
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt == TO_LIMIT) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                to_cnt    <= '0;
            end else begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ps2_keypress_capture.sv
// Directed bench for ps2_keypress_capture: drives PS/2 frames bit by bit
// and checks the history word and the valid/error pulses.
module tb_ps2_keypress_capture;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ps2_clk = 1'b1;
    logic        ps2_dat = 1'b1;
    logic [15:0] key_press;
    logic        byte_valid;
    logic        frame_err;

    int checks = 0;
    int failures = 0;
    int bv_cnt = 0;
    int fe_cnt = 0;
    int both_cnt = 0;
    int bv_base;
    int fe_base;

    ps2_keypress_capture #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .key_press  (key_press),
        .byte_valid (byte_valid),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    // Count pulse cycles away from the active edge.
    always @(negedge clk) begin
        if (byte_valid) bv_cnt++;
        if (frame_err) fe_cnt++;
        if (byte_valid && frame_err) both_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_dat = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (8) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit(par);
        ps2_bit(stp);
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // Power-on reset
        repeat (3) @(negedge clk);
        chk("rst_kp", 32'(key_press), 32'h0000);
        chk("rst_bv", 32'(byte_valid), 32'h0);
        chk("rst_fe", 32'(frame_err), 32'h0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single make code 0x1C with pin-to-output latency check
        bv_base = bv_cnt; fe_base = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(logic'((8'h1C >> i) & 8'h01));
        ps2_bit(1'b0);
        @(negedge clk) ps2_dat = 1'b1;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("lat_kp_k1", 32'(key_press), 32'h0000);
        chk("lat_bv_k1", 32'(byte_valid), 32'h0);
        @(posedge clk);
        #1;
        chk("lat_kp_k2", 32'(key_press), 32'h001C);
        chk("lat_bv_k2", 32'(byte_valid), 32'h1);
        @(posedge clk);
        #1;
        chk("lat_bv_k3", 32'(byte_valid), 32'h0);
        repeat (6) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (10) @(negedge clk);
        chk("make_bv_n", bv_cnt - bv_base, 1);
        chk("make_fe_n", fe_cnt - fe_base, 0);

        // Asynchronous reset mid-operation clears outputs without a clock edge
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        chk("arst_kp", 32'(key_press), 32'h0000);
        chk("arst_bv", 32'(byte_valid), 32'h0);
        chk("arst_fe", 32'(frame_err), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Release sequence 0x1C, 0xF0, 0x1C
        bv_base = bv_cnt; fe_base = fe_cnt;
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("rel_kp1", 32'(key_press), 32'h001C);
        send_frame(8'hF0, 1'b1, 1'b1);
        chk("rel_kp2", 32'(key_press), 32'h1CF0);
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("rel_kp3", 32'(key_press), 32'hF01C);
        chk("rel_bv_n", bv_cnt - bv_base, 3);
        chk("rel_fe_n", fe_cnt - fe_base, 0);

        // Bad parity then a good frame
        do_reset();
        send_frame(8'h1C, 1'b0, 1'b1);
        chk("bp_pre_kp", 32'(key_press), 32'h001C);
        bv_base = bv_cnt; fe_base = fe_cnt;
        send_frame(8'h16, 1'b1, 1'b1);
        chk("bp_kp", 32'(key_press), 32'h001C);
        chk("bp_fe_n", fe_cnt - fe_base, 1);
        chk("bp_bv_n", bv_cnt - bv_base, 0);
        send_frame(8'h26, 1'b0, 1'b1);
        chk("bp_next_kp", 32'(key_press), 32'h1C26);

        // Truncated frame: start plus 5 data bits, then idle past the timeout
        bv_base = bv_cnt; fe_base = fe_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(1'b1);
        repeat (TO + 100) @(negedge clk);
        chk("to_fe_n", fe_cnt - fe_base, 1);
        chk("to_bv_n", bv_cnt - bv_base, 0);
        chk("to_kp", 32'(key_press), 32'h1C26);
        send_frame(8'h45, 1'b0, 1'b1);
        chk("to_next_kp", 32'(key_press), 32'h2645);

        // Bad stop bit is discarded
        bv_base = bv_cnt; fe_base = fe_cnt;
        send_frame(8'h45, 1'b0, 1'b0);
        chk("stop_kp", 32'(key_press), 32'h2645);
        chk("stop_fe_n", fe_cnt - fe_base, 1);
        chk("stop_bv_n", bv_cnt - bv_base, 0);

        // Reset after the 4th falling edge, then a good 0x3C
        bv_base = bv_cnt; fe_base = fe_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        do_reset();
        repeat (TO + 50) @(negedge clk);
        chk("rmf_fe_n", fe_cnt - fe_base, 0);
        chk("rmf_bv_n", bv_cnt - bv_base, 0);
        send_frame(8'h3C, 1'b1, 1'b1);
        chk("rmf_kp", 32'(key_press), 32'h003C);
        chk("rmf_bv1_n", bv_cnt - bv_base, 1);

        chk("never_both", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
